dose_arbiter: RTL and testbench
===============================

DOSE_ARBITER -- requirements
Module: dose_arbiter

Interface
REQ-001 The block SHALL have a parameter PULSE_CYCLES, default 50000000, giving the number of cycles the motor output is held high per dose.
REQ-002 The block SHALL have a parameter SETTLE_CYCLES, default 1000000, giving the number of cycles compartment select is held stable before the motor pulse.
REQ-003 The block SHALL have a parameter GAP_CYCLES, default 25000000, giving the motor cooldown length in cycles between doses.
REQ-004 clock  in  1  sole clock; all logic is synchronous to its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 req  in  3  one-cycle dose requests from the schedule: bit0 morning, bit1 afternoon, bit2 evening.
REQ-007 mask  in  3  per-compartment enable; a req bit with a clear mask bit SHALL be ignored.
REQ-008 manual_req  in  1  one-cycle manual dose request, unmasked.
REQ-009 manual_sel  in  2  compartment index for manual_req (0..2); value 3 SHALL be ignored.
REQ-010 motor  out  1  dispense motor drive (GPIO).
REQ-011 sel  out  2  compartment gate select; 0..2, or 3 when idle.
REQ-012 busy  out  1  high whenever the FSM is not in IDLE.
REQ-013 pending  out  3  latched, not-yet-serviced requests.
REQ-014 overrun_cnt  out  8  count of dropped requests, saturating.

Function
REQ-015 An accepted request for compartment k on cycle N SHALL set pending[k] from cycle N+1.
REQ-016 A request for k while pending[k] is already set SHALL leave pending unchanged and increment overrun_cnt, which saturates at 255.
REQ-017 Simultaneous requests SHALL all latch; if scheduled and manual requests hit the same k in one cycle, the block SHALL latch once and count no overrun.
REQ-018 The FSM states SHALL be IDLE, SELECT, PULSE and GAP.
REQ-019 IDLE SHALL go to SELECT on the cycle after pending becomes nonzero, choosing the lowest set index (fixed priority 0>1>2) and registering it onto sel.
REQ-020 SELECT SHALL last exactly SETTLE_CYCLES cycles with motor low.
REQ-021 Entering PULSE SHALL clear pending[sel], and a new request for sel during PULSE or GAP SHALL re-set that bit without counting an overrun.
REQ-022 In PULSE, motor SHALL be high for exactly PULSE_CYCLES consecutive cycles.
REQ-023 GAP SHALL last exactly GAP_CYCLES cycles with motor low and sel held, then go to IDLE, where sel=3.
REQ-024 Priority SHALL be re-evaluated only in IDLE; an in-progress dose is never preempted.
REQ-025 A parameter value of 0 SHALL be treated as 1.

Reset
REQ-026 While reset is high the block SHALL set state=IDLE, motor=0, sel=3, busy=0, pending=0, overrun_cnt=0 and clear the timer.
REQ-027 Reset SHALL take priority over all inputs, and a reset asserted mid-PULSE SHALL drop motor on the next edge and discard the dose.

Configuration
REQ-028 With macro DISPENSE_CONFIRM_EN defined, the block SHALL add parameter CONFIRM_CYCLES (default 100000000), input confirm (1 bit, pill-drop sensor) and output fault (1 bit), plus a WAIT_CONFIRM state between PULSE and GAP.
REQ-029 WAIT_CONFIRM SHALL go to GAP on the first cycle confirm is high.
REQ-030 After CONFIRM_CYCLES cycles without confirm, the block SHALL pulse fault for one cycle, increment overrun_cnt (saturating) and go to GAP.
REQ-031 Without DISPENSE_CONFIRM_EN, the confirm and fault ports and the WAIT_CONFIRM state SHALL be absent, and PULSE SHALL go directly to GAP.

Structure
REQ-032 The state enum, the compartment index constants (MORNING=0, AFTERNOON=1, EVENING=2, NONE=3) and the overrun counter width SHALL live in shared package dispenser_pkg.
REQ-033 A single sub-module dispense_timer SHALL provide the loadable down-counter with a one-cycle done flag, reused by all timed states.

Verification
REQ-034 Bench parameters SHALL be PULSE=4, SETTLE=2 and GAP=3.
REQ-035 Scenario 1: req=001 and mask=111 at cycle 0 -> pending=001 at cycle 1, sel=0 at cycle 2, motor high during cycles 4-7, busy low from cycle 11.
REQ-036 Scenario 2: req=111 in one cycle -> three doses in order sel 0, 1, 2, with pending stepping 111, 110, 100, 000.
REQ-037 Scenario 3: req=010 with mask=101 -> no dose, pending=000, overrun_cnt=0.
REQ-038 Scenario 4: req=100 issued twice while pending[2] is set -> overrun_cnt=2, one dose only; 300 repeats -> overrun_cnt=255.
REQ-039 Scenario 5: reset pulsed at the second PULSE cycle -> motor=0, sel=3 and pending=0 on the next edge, with no further activity.
REQ-040 Scenario 6 (DISPENSE_CONFIRM_EN defined, CONFIRM=5): no confirm -> fault one-cycle pulse 5 cycles after PULSE ends and overrun_cnt increments; confirm on the 2nd wait cycle -> GAP follows immediately and fault stays 0.

Source files
------------

// File: rtl/dispenser_pkg.sv
// Shared types and constants for the dose arbiter.
// DISPENSE_CONFIRM_EN adds the WAIT_CONFIRM state.
package dispenser_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        PULSE,
        GAP
`ifdef DISPENSE_CONFIRM_EN
        , WAIT_CONFIRM
`endif
    } state_t;

    localparam logic [1:0] MORNING   = 2'd0;
    localparam logic [1:0] AFTERNOON = 2'd1;
    localparam logic [1:0] EVENING   = 2'd2;
    localparam logic [1:0] NONE      = 2'd3;

    localparam int OVR_W = 8;
    localparam int TMR_W = 32;

    // Timer counts n-1 down to 0; a zero length behaves as one cycle.
    function automatic logic [TMR_W-1:0] cyc_load(int unsigned n);
        return (n == 0) ? '0 : TMR_W'(n - 1);
    endfunction

    function automatic logic [1:0] first_set(logic [2:0] p);
        if (p[0])
            return MORNING;
        else if (p[1])
            return AFTERNOON;
        else if (p[2])
            return EVENING;
        else
            return NONE;
    endfunction

    function automatic logic [1:0] pop3(logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

endpackage

// File: rtl/dose_arbiter_if.sv
// Request/status bundle of the dose arbiter.
// DISPENSE_CONFIRM_EN adds confirm and fault.
interface dose_arbiter_if;
    import dispenser_pkg::*;

    logic [2:0]       req;
    logic [2:0]       mask;
    logic             manual_req;
    logic [1:0]       manual_sel;
    logic             motor;
    logic [1:0]       sel;
    logic             busy;
    logic [2:0]       pending;
    logic [OVR_W-1:0] overrun_cnt;
`ifdef DISPENSE_CONFIRM_EN
    logic             confirm;
    logic             fault;
`endif

    modport master (
        output req, mask, manual_req, manual_sel,
`ifdef DISPENSE_CONFIRM_EN
        output confirm,
        input  fault,
`endif
        input  motor, sel, busy, pending, overrun_cnt
    );

    modport slave (
        input  req, mask, manual_req, manual_sel,
`ifdef DISPENSE_CONFIRM_EN
        input  confirm,
        output fault,
`endif
        output motor, sel, busy, pending, overrun_cnt
    );

endinterface

// File: rtl/dispense_timer.sv
// Loadable down-counter; done pulses once when a loaded count expires.
module dispense_timer
    import dispenser_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [TMR_W-1:0] value,
    output logic             done
);

    logic [TMR_W-1:0] cnt;
    logic             active;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt    <= '0;
            active <= 1'b0;
        end else if (load) begin
            cnt    <= value;
            active <= 1'b1;
        end else if (active) begin
            if (cnt == '0)
                active <= 1'b0;
            else
                cnt <= cnt - 1'b1;
        end
    end

    assign done = active && (cnt == '0);

endmodule

// File: rtl/dose_arbiter.sv
// Pill dispenser arbiter: latches dose requests and runs one dose at a time.
// DISPENSE_CONFIRM_EN adds a pill-drop confirm wait with timeout fault.
module dose_arbiter
    import dispenser_pkg::*;
#(
    parameter int unsigned PULSE_CYCLES  = 50000000,
    parameter int unsigned SETTLE_CYCLES = 1000000,
    parameter int unsigned GAP_CYCLES    = 25000000
`ifdef DISPENSE_CONFIRM_EN
    , parameter int unsigned CONFIRM_CYCLES = 100000000
`endif
) (
    input logic           clock,
    input logic           reset,
    dose_arbiter_if.slave bus
);

    state_t           state;
    logic [2:0]       pending_q;
    logic [OVR_W-1:0] ovr_q;
    logic             motor_q;
    logic [1:0]       sel_q;
    logic             busy_q;
    logic             fault_q;

    logic [2:0]       hits;
    logic [2:0]       clr;
    logic [2:0]       drop;
    logic [2:0]       ovr_inc;
    logic [OVR_W:0]   ovr_sum;
    logic [OVR_W-1:0] ovr_n;
    logic             timeout;
    logic             tmr_load;
    logic             tmr_done;
    logic [TMR_W-1:0] tmr_val;

    dispense_timer u_timer (
        .clock (clock),
        .reset (reset),
        .load  (tmr_load),
        .value (tmr_val),
        .done  (tmr_done)
    );

    always_comb begin
        hits = bus.req & bus.mask;
        if (bus.manual_req && bus.manual_sel != NONE)
            hits = hits | (3'b001 << bus.manual_sel);
    end

    // The bit being serviced is cleared first, so a same-cycle request relatches it.
    assign clr  = (state == SELECT && tmr_done) ? (3'b001 << sel_q) : 3'b000;
    assign drop = hits & pending_q & ~clr;

    assign ovr_inc = {1'b0, pop3(drop)} + {2'b00, timeout};
    assign ovr_sum = {1'b0, ovr_q} + (OVR_W+1)'(ovr_inc);
    assign ovr_n   = ovr_sum[OVR_W] ? {OVR_W{1'b1}} : ovr_sum[OVR_W-1:0];

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        timeout  = 1'b0;
        unique case (state)
            IDLE: begin
                if (|pending_q) begin
                    tmr_load = 1'b1;
                    tmr_val  = cyc_load(SETTLE_CYCLES);
                end
            end
            SELECT: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = cyc_load(PULSE_CYCLES);
                end
            end
            PULSE: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
`ifdef DISPENSE_CONFIRM_EN
                    tmr_val  = cyc_load(CONFIRM_CYCLES);
`else
                    tmr_val  = cyc_load(GAP_CYCLES);
`endif
                end
            end
`ifdef DISPENSE_CONFIRM_EN
            WAIT_CONFIRM: begin
                if (bus.confirm || tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = cyc_load(GAP_CYCLES);
                    timeout  = !bus.confirm;
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            pending_q <= '0;
            ovr_q     <= '0;
            motor_q   <= 1'b0;
            sel_q     <= NONE;
            busy_q    <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            pending_q <= (pending_q & ~clr) | hits;
            ovr_q     <= ovr_n;
            fault_q   <= timeout;
            unique case (state)
                IDLE: begin
                    if (|pending_q) begin
                        state  <= SELECT;
                        sel_q  <= first_set(pending_q);
                        busy_q <= 1'b1;
                    end
                end
                SELECT: begin
                    if (tmr_done) begin
                        state   <= PULSE;
                        motor_q <= 1'b1;
                    end
                end
                PULSE: begin
                    if (tmr_done) begin
                        motor_q <= 1'b0;
`ifdef DISPENSE_CONFIRM_EN
                        state   <= WAIT_CONFIRM;
`else
                        state   <= GAP;
`endif
                    end
                end
`ifdef DISPENSE_CONFIRM_EN
                WAIT_CONFIRM: begin
                    if (bus.confirm || tmr_done)
                        state <= GAP;
                end
`endif
                GAP: begin
                    if (tmr_done) begin
                        state  <= IDLE;
                        sel_q  <= NONE;
                        busy_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.motor       = motor_q;
    assign bus.sel         = sel_q;
    assign bus.busy        = busy_q;
    assign bus.pending     = pending_q;
    assign bus.overrun_cnt = ovr_q;
`ifdef DISPENSE_CONFIRM_EN
    assign bus.fault       = fault_q;
`endif

endmodule

// File: tb/tb_dose_arbiter.sv
// Self-checking bench for dose_arbiter against a dose-timeline model.
// Define DISPENSE_CONFIRM_EN to exercise the confirm path.
module tb_dose_arbiter;
    import dispenser_pkg::*;

    localparam int S = 2;
    localparam int P = 4;
    localparam int G = 3;
`ifdef DISPENSE_CONFIRM_EN
    localparam int C = 5;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    dose_arbiter_if bus();

    dose_arbiter #(
        .PULSE_CYCLES  (P),
        .SETTLE_CYCLES (S),
        .GAP_CYCLES    (G)
`ifdef DISPENSE_CONFIRM_EN
        , .CONFIRM_CYCLES (C)
`endif
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    // Model: pending bits, overrun count, and the active dose as (compartment, age).
    // age 1 is the first SELECT cycle; gs is the age of the first GAP cycle.
    int m_pend, m_ovr, m_k, m_age, m_gs, m_fault;

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend  = 0;
        m_ovr   = 0;
        m_k     = -1;
        m_age   = 0;
        m_gs    = 0;
        m_fault = 0;
    endtask

    task automatic compare();
        int e_sel, e_busy, e_motor;
        e_busy  = (m_k >= 0) ? 1 : 0;
        e_sel   = (m_k >= 0) ? m_k : 3;
        e_motor = (m_k >= 0 && m_age > S && m_age <= S + P) ? 1 : 0;
        chk("motor", 32'(bus.motor), e_motor);
        chk("sel", 32'(bus.sel), e_sel);
        chk("busy", 32'(bus.busy), e_busy);
        chk("pending", 32'(bus.pending), m_pend);
        chk("overrun_cnt", 32'(bus.overrun_cnt), m_ovr);
`ifdef DISPENSE_CONFIRM_EN
        chk("fault", 32'(bus.fault), m_fault);
`endif
    endtask

    task automatic model_step();
        int hits, clr, inc;
        hits = int'(bus.req & bus.mask);
        if (bus.manual_req && bus.manual_sel != 2'd3)
            hits = hits | (1 << bus.manual_sel);
        if (reset) begin
            model_reset();
            return;
        end
        clr = (m_k >= 0 && m_age == S) ? (1 << m_k) : 0;
        inc = $countones(hits & m_pend & ~clr);
        m_fault = 0;
        if (m_k < 0) begin
            if (m_pend != 0) begin
                m_k   = m_pend[0] ? 0 : (m_pend[1] ? 1 : 2);
                m_age = 1;
`ifdef DISPENSE_CONFIRM_EN
                m_gs  = 0;
`else
                m_gs  = S + P + 1;
`endif
            end
        end else begin
`ifdef DISPENSE_CONFIRM_EN
            if (m_age > S + P && m_gs == 0) begin
                if (bus.confirm) begin
                    m_gs = m_age + 1;
                end else if (m_age == S + P + C) begin
                    m_gs    = m_age + 1;
                    m_fault = 1;
                    inc++;
                end
            end
`endif
            if (m_gs != 0 && m_age == m_gs + G - 1)
                m_k = -1;
            else
                m_age++;
        end
        m_ovr  = (m_ovr + inc > 255) ? 255 : m_ovr + inc;
        m_pend = (m_pend & ~clr) | hits;
    endtask

    task automatic tick();
        compare();
        model_step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int sels[$];
        int pends[$];
        int last_sel, last_p, seen, rises, prev_m;

        bus.req        = '0;
        bus.mask       = 3'b111;
        bus.manual_req = 1'b0;
        bus.manual_sel = 2'd0;
`ifdef DISPENSE_CONFIRM_EN
        bus.confirm    = 1'b0;
`endif
        model_reset();
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        chk("rst_motor", 32'(bus.motor), 0);
        chk("rst_sel", 32'(bus.sel), 3);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_pending", 32'(bus.pending), 0);
        chk("rst_overrun", 32'(bus.overrun_cnt), 0);
        reset = 1'b0;

        // Scenario 1: single morning dose with literal timeline.
        bus.req = 3'b001;
        for (int c = 0; c <= 12; c++) begin
            if (c > 0) begin
                chk("s1_pending", 32'(bus.pending), (c >= 1 && c <= 3) ? 1 : 0);
                chk("s1_sel", 32'(bus.sel), (c >= 2 && c <= 10) ? 0 : 3);
                chk("s1_motor", 32'(bus.motor), (c >= 4 && c <= 7) ? 1 : 0);
                chk("s1_busy", 32'(bus.busy), (c >= 2 && c <= 10) ? 1 : 0);
            end
            tick();
            bus.req = '0;
        end

        // Scenario 2: all three at once, serviced in priority order.
        last_sel = 3;
        last_p   = -1;
        bus.req  = 3'b111;
        for (int c = 0; c < 40; c++) begin
            tick();
            bus.req = '0;
            if (bus.sel != 2'd3 && int'(bus.sel) != last_sel)
                sels.push_back(int'(bus.sel));
            last_sel = int'(bus.sel);
            if (int'(bus.pending) != last_p) begin
                pends.push_back(int'(bus.pending));
                last_p = int'(bus.pending);
            end
        end
        chk("s2_ndoses", sels.size(), 3);
        for (int i = 0; i < 3; i++)
            chk("s2_order", (i < sels.size()) ? sels[i] : 99, i);
        chk("s2_npend", pends.size(), 4);
        chk("s2_pend0", (pends.size() > 0) ? pends[0] : 99, 7);
        chk("s2_pend1", (pends.size() > 1) ? pends[1] : 99, 6);
        chk("s2_pend2", (pends.size() > 2) ? pends[2] : 99, 4);
        chk("s2_pend3", (pends.size() > 3) ? pends[3] : 99, 0);

        // Scenario 3: masked request is ignored.
        seen     = 0;
        bus.mask = 3'b101;
        bus.req  = 3'b010;
        for (int c = 0; c < 12; c++) begin
            tick();
            bus.req = '0;
            if (bus.busy) seen = 1;
        end
        chk("s3_pending", 32'(bus.pending), 0);
        chk("s3_overrun", 32'(bus.overrun_cnt), 0);
        chk("s3_busy_seen", seen, 0);
        bus.mask = 3'b111;

        // Scenario 4: repeated evening requests overrun, then saturate.
        rises  = 0;
        prev_m = 0;
        for (int c = 0; c < 15; c++) begin
            bus.req = (c < 3) ? 3'b100 : 3'b000;
            tick();
            if (bus.motor && !prev_m) rises++;
            prev_m = int'(bus.motor);
        end
        chk("s4_overrun2", 32'(bus.overrun_cnt), 2);
        chk("s4_one_dose", rises, 1);
        bus.req = 3'b100;
        for (int c = 0; c < 300; c++) tick();
        bus.req = '0;
        chk("s4_saturate", 32'(bus.overrun_cnt), 255);
        for (int c = 0; c < 12; c++) tick();

        // Scenario 5: reset during the second pulse cycle discards the dose.
        do_reset();
        bus.req = 3'b011;
        for (int c = 0; c <= 5; c++) begin
            if (c == 5) begin
                chk("s5_motor_pre", 32'(bus.motor), 1);
                chk("s5_pend_pre", 32'(bus.pending), 2);
                reset = 1'b1;
            end
            tick();
            bus.req = '0;
        end
        reset = 1'b0;
        chk("s5_motor", 32'(bus.motor), 0);
        chk("s5_sel", 32'(bus.sel), 3);
        chk("s5_pending", 32'(bus.pending), 0);
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (bus.busy || bus.motor) seen = 1;
        end
        chk("s5_quiet", seen, 0);

`ifdef DISPENSE_CONFIRM_EN
        // Scenario 6a: no confirm, timeout fault.
        do_reset();
        bus.req = 3'b001;
        for (int c = 0; c <= 17; c++) begin
            if (c > 0) begin
                chk("s6_fault", 32'(bus.fault), (c == 13) ? 1 : 0);
                if (c == 12) chk("s6_ovr_pre", 32'(bus.overrun_cnt), 0);
                if (c == 13) chk("s6_ovr_post", 32'(bus.overrun_cnt), 1);
                if (c == 16) chk("s6_idle", 32'(bus.busy), 0);
            end
            tick();
            bus.req = '0;
        end
        // Scenario 6b: confirm on second wait cycle.
        do_reset();
        bus.req = 3'b001;
        for (int c = 0; c <= 14; c++) begin
            if (c > 0) begin
                chk("s6b_fault", 32'(bus.fault), 0);
                if (c == 10) chk("s6b_gap_motor", 32'(bus.motor), 0);
                if (c == 12) chk("s6b_gap_busy", 32'(bus.busy), 1);
                if (c == 13) chk("s6b_idle", 32'(bus.busy), 0);
            end
            bus.confirm = (c == 9);
            tick();
            bus.req = '0;
        end
        bus.confirm = 1'b0;
        chk("s6b_overrun", 32'(bus.overrun_cnt), 0);
`endif

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            bus.req = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            bus.mask = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b111;
            bus.manual_req = ($urandom_range(0, 11) == 0);
            bus.manual_sel = 2'($urandom_range(0, 3));
            reset = ($urandom_range(0, 299) == 0);
`ifdef DISPENSE_CONFIRM_EN
            bus.confirm = ($urandom_range(0, 3) == 0);
`endif
            tick();
        end
        reset = 1'b0;
        bus.req = '0;
        bus.manual_req = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
